// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: Moore FSM sequencing load/clear/add/shift enables for a shift-add multiplier
module seq_mul_ctrl #(
   parameter int N  = 4,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          q0,
   output logic          ld_ops,
   output logic          clr_acc,
   output logic          add_en,
   output logic          shift_en,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] TEST  = 3'd2;
   localparam logic [2:0] ADD   = 3'd3;
   localparam logic [2:0] SHIFT = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;
   logic [2:0] state, nxt;
   // next state; unused encodings fall back to IDLE
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = start ? LOAD : IDLE;
         LOAD:    nxt = TEST;
         TEST:    nxt = q0 ? ADD : SHIFT;
         ADD:     nxt = SHIFT;
         SHIFT:   nxt = (count == CW'(N - 1)) ? DONE : TEST;
         default: nxt = IDLE;
      endcase
   end
   // state register and iteration counter, cleared on LOAD and bumped on every shift
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= nxt;
         if (state == LOAD) count <= '0;
         else if (state == SHIFT) count <= count + 1'b1;
      end
   end
   assign ld_ops   = state == LOAD;
   assign clr_acc  = state == LOAD;
   assign add_en   = state == ADD;
   assign shift_en = state == SHIFT;
   assign busy     = state == LOAD || state == TEST || state == ADD || state == SHIFT;
   assign done     = state == DONE;
endmodule
